// File: rtl/xalu_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: opcodes, FSM states
// and the slice width.
package xalu_pkg;

    localparam int NIB_W = 4;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_AND   = 3'd1;
    localparam logic [2:0] OP_OR    = 3'd2;
    localparam logic [2:0] OP_XOR   = 3'd3;
    localparam logic [2:0] OP_PASSA = 3'd4;
    localparam logic [2:0] OP_PASSB = 3'd5;
    localparam logic [2:0] OP_SHR   = 3'd6;
    localparam logic [2:0] OP_SHL   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/xalu_nibble_seq.sv
// Drives an external combinational 4-bit ALU slice one nibble per cycle and
// assembles the full-width result, word carry and status flags.
module xalu_nibble_seq
    import xalu_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = NIB_W * NIBBLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             com,
    input  logic             cin,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     result,
    output logic             cout,
    output logic             zero,
    output logic             neg_zero,
    output logic             equ,
    output logic [NIB_W-1:0] slice_da,
    output logic [NIB_W-1:0] slice_db,
    output logic [2:0]       slice_f,
    output logic             slice_com,
    output logic             slice_ci_right,
    output logic             slice_ci_left,
    input  logic [NIB_W-1:0] slice_d,
    input  logic             slice_co_left,
    input  logic             slice_co_right,
    input  logic             slice_equ,
    output state_t           dbg_state
);

    localparam int IW = $clog2(NIBBLES);

    state_t         r_state;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [2:0]     r_op;
    logic           r_com;
    logic [IW-1:0]  r_idx;
    logic           r_carry;
    logic           r_equ_acc;
    logic [W-1:0]   r_acc;
    logic [W-1:0]   r_result;
    logic           r_cout;
    logic           r_zero;
    logic           r_neg_zero;
    logic           r_equ;
    logic           r_busy;
    logic           r_done;

    logic           w_run;
    logic           w_shr;
    logic           w_last;
    logic           w_co;
    logic           w_cout_kept;
    logic [W-1:0]   w_acc_next;

    assign w_run       = (r_state == RUN);
    assign w_shr       = (r_op == OP_SHR);
    // SHR walks MSB to LSB, everything else LSB to MSB.
    assign w_last      = w_shr ? (r_idx == '0) : (r_idx == IW'(NIBBLES - 1));
    assign w_co        = w_shr ? slice_co_right : slice_co_left;
    assign w_cout_kept = (r_op == OP_ADD) || (r_op == OP_SHR) || (r_op == OP_SHL);

    always_comb begin
        w_acc_next = r_acc;
        w_acc_next[int'(r_idx)*NIB_W +: NIB_W] = slice_d;
    end

    // Slice inputs come straight from registers so the slice sees a full cycle.
    assign slice_da       = w_run ? r_a[int'(r_idx)*NIB_W +: NIB_W] : '0;
    assign slice_db       = w_run ? r_b[int'(r_idx)*NIB_W +: NIB_W] : '0;
    assign slice_f        = w_run ? r_op : 3'd0;
    assign slice_com      = w_run & r_com;
    assign slice_ci_right = w_run & ~w_shr & r_carry;
    assign slice_ci_left  = w_run &  w_shr & r_carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= OP_ADD;
            r_com      <= 1'b0;
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_equ_acc  <= 1'b0;
            r_acc      <= '0;
            r_result   <= '0;
            r_cout     <= 1'b0;
            r_zero     <= 1'b0;
            r_neg_zero <= 1'b0;
            r_equ      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a       <= a;
                        r_b       <= b;
                        r_op      <= op;
                        r_com     <= com;
                        r_carry   <= cin;
                        r_equ_acc <= 1'b1;
                        r_idx     <= (op == OP_SHR) ? IW'(NIBBLES - 1) : '0;
                        r_busy    <= 1'b1;
                        r_state   <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_acc     <= w_acc_next;
                    r_carry   <= w_co;
                    r_equ_acc <= r_equ_acc & slice_equ;
                    if (w_last) begin
                        r_result   <= w_acc_next;
                        r_cout     <= w_cout_kept & w_co;
                        r_zero     <= (w_acc_next == '0);
                        r_neg_zero <= &w_acc_next;
                        r_equ      <= r_equ_acc & slice_equ;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= DONE;
                    end else begin
                        r_idx <= w_shr ? (r_idx - IW'(1)) : (r_idx + IW'(1));
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign cout      = r_cout;
    assign zero      = r_zero;
    assign neg_zero  = r_neg_zero;
    assign equ       = r_equ;
    assign dbg_state = r_state;

endmodule
